// File: rtl/pc_fetch_unit.sv
// PC register and fetch control for the single-cycle RV32I core: next-PC selection, fetch gating and a sticky redirect fault.
// Optional FETCH_BOUND_CHECK_EN: a next PC beyond instruction memory faults instead of wrapping.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [31:0]        jump_target,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_en,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic [31:0]        fetch_count,
    output logic               fault,
    output logic [31:0]        fault_pc
);

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BOUND_CHECK_EN
    localparam logic [31:0] FETCH_LIMIT = 32'(4) << IMEM_AW;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] target;
    logic        redirect;
    logic        bad_target;
    logic        pc_load;
    logic        fault_load;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc[IMEM_AW+1:2];
    assign fault     = (state == FAULT);
    assign instr     = instr_valid ? imem_rdata : NOP;

    // Target and its legality are computed every cycle; only RUN without stall acts on them.
    always_comb begin
        target   = pc_plus4;
        redirect = 1'b0;
        if (jump) begin
            target   = jump_target;
            redirect = 1'b1;
        end else if (branch_taken) begin
            target   = branch_target;
            redirect = 1'b1;
        end
        bad_target = redirect && (target[1:0] != 2'b00);
`ifdef FETCH_BOUND_CHECK_EN
        bad_target = bad_target || (target >= FETCH_LIMIT);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        imem_en     = 1'b0;
        instr_valid = 1'b0;
        pc_load     = 1'b0;
        fault_load  = 1'b0;
        case (state)
            IDLE: begin
                state_next = RUN;
            end
            RUN: begin
                imem_en     = 1'b1;
                instr_valid = !stall;
                if (!stall) begin
                    if (bad_target) begin
                        state_next = FAULT;
                        fault_load = 1'b1;
                    end else begin
                        pc_load = 1'b1;
                    end
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            fetch_count <= 32'd0;
            fault_pc    <= 32'd0;
        end else begin
            if (pc_load) begin
                pc <= target;
            end
            if (fault_load) begin
                fault_pc <= target;
            end
            if (instr_valid) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit against a behavioural fetch model.
module tb_pc_fetch_unit;

    localparam int W = 136;
`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND_ON = 1'b1;
`else
    localparam bit BOUND_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [4:0]  imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] fetch_count;
    logic        fault;
    logic [31:0] fault_pc;

    logic [31:0] mem [32];
    logic [W-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic [31:0] m_fault_pc;
    bit          m_started;
    bit          m_fault;

    pc_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .fetch_count  (fetch_count),
        .fault        (fault),
        .fault_pc     (fault_pc)
    );

    assign imem_rdata = mem[imem_addr];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // expected outputs for the current cycle given current inputs
    function automatic logic [W-1:0] expect_now(input bit s);
        bit          active;
        bit          v;
        logic [31:0] ins;
        logic [4:0]  idx;
        active = m_started && !m_fault;
        v      = active && !s;
        idx    = m_pc[6:2];
        ins    = v ? mem[idx] : 32'h0000_0013;
        return {m_pc, idx, active, v, ins, m_count, m_fault, m_fault_pc};
    endfunction

    task automatic model_reset();
        m_pc       = 32'h0;
        m_count    = 32'h0;
        m_fault_pc = 32'h0;
        m_started  = 1'b0;
        m_fault    = 1'b0;
    endtask

    // apply the effect of the coming clock edge to the model
    task automatic model_edge(input bit s, input bit j, input logic [31:0] jt,
                              input bit b, input logic [31:0] bt);
        logic [31:0] nxt;
        bit          redir;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (!m_fault && !s) begin
            m_count = m_count + 1;
            redir = j || b;
            nxt   = j ? jt : (b ? bt : m_pc + 4);
            if ((redir && nxt[1:0] != 2'b00) || (BOUND_ON && nxt >= 32'd128)) begin
                m_fault    = 1'b1;
                m_fault_pc = nxt;
            end else begin
                m_pc = nxt;
            end
        end
    endtask

    // driver: called at posedge+1, leaves at the next posedge+1
    task automatic step(input bit s, input bit j, input logic [31:0] jt,
                        input bit b, input logic [31:0] bt);
        stall         = s;
        jump          = j;
        jump_target   = jt;
        branch_taken  = b;
        branch_target = bt;
        exp_q.push_back(expect_now(s));
        model_edge(s, j, jt, b, bt);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall        = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        rst          = 1'b1;
        model_reset();
        exp_q.push_back(expect_now(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_target();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'($urandom_range(0, 31) << 2) | 32'($urandom_range(1, 3));
        if (r == 1) return $urandom & 32'hFFFF_FFFC;
        return 32'($urandom_range(0, 31) << 2);
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc",          pc,                  e[135:104]);
            chk("pc_plus4",    pc_plus4,            e[135:104] + 32'd4);
            chk("imem_addr",   32'(imem_addr),      32'(e[103:99]));
            chk("imem_en",     32'(imem_en),        32'(e[98]));
            chk("instr_valid", 32'(instr_valid),    32'(e[97]));
            chk("instr",       instr,               e[96:65]);
            chk("fetch_count", fetch_count,         e[64:33]);
            chk("fault",       32'(fault),          32'(e[32]));
            chk("fault_pc",    fault_pc,            e[31:0]);
        end
    end

    initial begin
        int fault_cycles;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        rst = 1'b1; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        jump_target = 32'h0; branch_target = 32'h0;
        model_reset();
        @(posedge clk);
        #1;

        // reset, bubble, then sequential fetch
        do_reset();
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0);
        // stall at pc=8 with redirects held; they must be ignored
        for (int i = 0; i < 3; i++) step(1, 1, 32'h40, 1, 32'h23);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0);
        // pc=16: jump beats branch, then branch alone
        step(0, 1, 32'h4, 1, 32'h20);
        step(0, 0, 0, 1, 32'h20);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
        // misaligned branch faults and stays faulted
        step(0, 0, 0, 1, 32'h22);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h8, 0, 0);

        // misaligned jump wins over aligned branch
        do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 1, 32'h11, 1, 32'h10);
        step(0, 0, 0, 0, 0);

        // run across the top of instruction memory
        do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 1, 32'h74, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);

        // PC wrap at the top of the address space
        do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 1, 32'hFFFF_FFFC, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

        // randomized traffic with resets after faults
        do_reset();
        fault_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_fault) fault_cycles++;
            if (fault_cycles > 3) begin
                fault_cycles = 0;
                do_reset();
            end
            step($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, rand_target(),
                 $urandom_range(0, 5) == 0, rand_target());
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and fetch-control stage of the single-cycle RV32I core. It sits directly upstream of the instruction memory: it owns the PC register, drives the memory's 5-bit word index and enable, and selects the next PC from sequential, branch and jump sources. It gates the fetched word into a valid-qualified instruction for decode, and traps misaligned redirects into a sticky fault state.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_AW, 5, instruction-memory word-index width (32 words).

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and suppress instr_valid this cycle.
- branch_taken  input  1  branch resolved taken this cycle.
- branch_target  input  32  branch destination.
- jump  input  1  JAL/JALR redirect this cycle.
- jump_target  input  32  jump destination.
- imem_addr  output  IMEM_AW  word index = pc[IMEM_AW+1:2].
- imem_en  output  1  instruction-memory enable.
- imem_rdata  input  32  word returned combinationally by instruction memory.
- pc  output  32  current PC.
- pc_plus4  output  32  pc + 4, modulo 2^32.
- instr  output  32  instruction to decode; 32'h0000_0013 (NOP) when not valid.
- instr_valid  output  1  instr is a real fetched instruction.
- fetch_count  output  32  number of cycles with instr_valid high; wraps at 2^32.
- fault  output  1  sticky misaligned-redirect (or bound) fault.
- fault_pc  output  32  offending target address captured on fault.

## Operation
- States: IDLE, RUN, FAULT. Reset → IDLE.
- IDLE: imem_en=0, instr_valid=0, PC held. Unconditionally → RUN next cycle (one bubble after reset release).
- RUN: imem_en=1; instr_valid = !stall; instr = imem_rdata when valid, else NOP.
- Next-PC priority in RUN: stall (hold) > jump > branch_taken > pc+4.
- Stall holds PC; redirects asserted during stall are ignored. The controller keeps them asserted until stall drops.
- A redirect target with bits[1:0] ≠ 0 → FAULT: PC not updated, fault_pc ← target, fault ← 1. The instruction in the current cycle is still valid.
- FAULT: imem_en=0, instr_valid=0, PC frozen. Exit only via rst.
- fetch_count increments on each cycle instr_valid=1.
- Adders: 32-bit unsigned, carry discarded; PC wraps 32'hFFFF_FFFC → 0.

## Timing
- Reset values: pc=RESET_PC, pc_plus4=RESET_PC+4, imem_en=0, imem_addr=RESET_PC[IMEM_AW+1:2], instr=NOP, instr_valid=0, fetch_count=0, fault=0, fault_pc=0, state IDLE.
- Assertion of rst takes effect immediately (asynchronous); the first RUN cycle is the second rising edge after release.
- imem_addr, imem_en, pc, pc_plus4 are registered-state outputs. They change only after a clock edge or rst.
- instr and instr_valid are combinational from state, stall and imem_rdata (zero-cycle fetch latency).
- A redirect sampled at edge N drives imem_addr from the new PC in cycle N+1. Redirect penalty is 0 cycles.
- jump and branch_taken asserted together: jump_target wins. A misaligned jump_target faults even if branch_target is aligned.
- rst mid-FAULT or mid-stall returns to IDLE with all reset values.

## Configuration
- FETCH_BOUND_CHECK_EN defined: a next PC ≥ 4·2^IMEM_AW (sequential or redirect) enters FAULT with fault_pc ← that PC. PC is not updated.
- Not defined: no bound check. imem_addr takes the low index bits, so fetch wraps modulo instruction-memory size. Only misalignment faults.

## Test plan
- Reset: assert rst, release; cycle 1 imem_en=0, instr=32'h13, valid=0. Cycle 2 pc=0, imem_en=1, valid=1.
- Sequential: 8 free-running cycles → pc steps 0,4,…,28; imem_addr 0..7; fetch_count=8.
- Stall: at pc=8 hold stall for 3 cycles → pc stays 8, valid=0, fetch_count frozen; release → pc=12 next edge.
- Redirect priority: at pc=16 assert jump (target 0x4) with branch_taken (target 0x20) → pc=0x4. Branch alone to 0x20 → pc=0x20.
- Misaligned: branch_target=0x22 taken → fault=1, fault_pc=0x22, imem_en=0, pc unchanged; only rst clears it.
- Bound (macro on): run from pc=0x7C → fault, fault_pc=0x80. Macro off: pc=0x80, imem_addr=0.
